// File: rtl/lynxTypes.sv
// Shared platform types for the DDR stripe path.
// Holds bus widths, sequence-entry layout and the sub-burst bundle.
package lynxTypes;

   localparam int N_DDR_CHAN      = 2;
   localparam int N_DDR_CHAN_BITS = 1;
   localparam int AXI_ADDR_BITS   = 64;
   localparam int AXI_ID_BITS     = 6;
   localparam int AXI_DATA_BITS   = 512;

   // Sequence entry: [7:0] awlen, [8] chan, [9] last.
   localparam int STRIPE_MUX_BITS = 10;
   localparam int STRIPE_MUX_CHAN = 8;
   localparam int STRIPE_MUX_LAST = 9;

   typedef struct packed {
      logic                       last;
      logic [N_DDR_CHAN_BITS-1:0] chan;
      logic [8:0]                 n;
      logic [AXI_ADDR_BITS-1:0]   laddr;
   } stripe_sub_t;

   function automatic logic [STRIPE_MUX_BITS-1:0] stripe_mux_pack(
      input logic       last,
      input logic       chan,
      input logic [7:0] len
   );
      logic [STRIPE_MUX_BITS-1:0] e;
      e                  = '0;
      e[7:0]             = len;
      e[STRIPE_MUX_CHAN] = chan;
      e[STRIPE_MUX_LAST] = last;
      return e;
   endfunction

endpackage

// File: rtl/metaIntf.sv
// Valid/ready stream carrying a fixed-width metadata word.
// m: producer (drives valid/data), s: consumer (drives ready).
interface metaIntf #(
   parameter int STYPE_BITS = 10
) ();

   logic                  valid;
   logic                  ready;
   logic [STYPE_BITS-1:0] data;

   modport m (output valid, output data, input ready);
   modport s (input valid, input data, output ready);

endinterface

// File: rtl/stripe_credit_cnt.sv
// Saturating up/down credit counter, reset to MAX.
// Ports: clk_i, rst_i (async high), inc_i, dec_i; zero_o = next count is 0.
module stripe_credit_cnt #(
   parameter int MAX = 16,
   parameter int W   = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam logic [W-1:0] MAXV = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // Simultaneous inc/dec cancel; inc at MAX and dec at 0 hold.
   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc_i, dec_i})
         2'b10:   if (cnt_q != MAXV) cnt_d = cnt_q + 1'b1;
         2'b01:   if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= MAXV;
      else       cnt_q <= cnt_d;
   end

   // Zero flag of the post-update count, so registered
   // ready decisions see this cycle's refill or spend.
   assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/axi_stripe_aw_sched.sv
// Splits AXI write requests at stripe boundaries into per-channel AWs.
// Ports: s_aw* request in, m_aw* sub-burst out, mux sequence out, b_cpl credit return.
module axi_stripe_aw_sched
   import lynxTypes::*;
#(
   parameter int STRIPE_BEATS    = 64,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [AXI_ADDR_BITS-1:0]   s_awaddr,
   input  logic [7:0]                 s_awlen,
   input  logic [AXI_ID_BITS-1:0]     s_awid,
   input  logic                       s_awvalid,
   output logic                       s_awready,
   output logic [AXI_ADDR_BITS-1:0]   m_awaddr,
   output logic [7:0]                 m_awlen,
   output logic [AXI_ID_BITS-1:0]     m_awid,
   output logic [N_DDR_CHAN_BITS-1:0] m_awchan,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   metaIntf.m                         mux,
   input  logic                       b_cpl
);

   localparam int AW         = AXI_ADDR_BITS;
   localparam int BEAT_LOG   = $clog2(AXI_DATA_BITS / 8);
   localparam int STRIPE_LOG = BEAT_LOG + $clog2(STRIPE_BEATS);

   localparam logic [AW-1:0] OFF_MASK =
      (AW'(1) << STRIPE_LOG) - AW'(1);

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } state_t;

   state_t                     state_q;
   logic [AW-1:0]              a_q;
   logic [8:0]                 rem_q;
   logic [8:0]                 n_q;
   logic                       last_q;
   logic                       aw_done_q;
   logic                       mx_done_q;
   logic                       s_awready_q;
   logic                       m_awvalid_q;
   logic                       mx_valid_q;
   logic [AW-1:0]              m_awaddr_q;
   logic [7:0]                 m_awlen_q;
   logic [AXI_ID_BITS-1:0]     m_awid_q;
   logic [N_DDR_CHAN_BITS-1:0] m_awchan_q;
   logic [STRIPE_MUX_BITS-1:0] mx_data_q;

   logic          accept;
   logic          aw_cmp;
   logic          mx_cmp;
   logic          cr_zero;
   logic [AW-1:0] a_nxt;
   logic [8:0]    rem_nxt;
   logic [AW-1:0] in_a;
   logic [8:0]    in_rem;
   stripe_sub_t   sp;

   // One sub-burst: cut at the stripe end, map stripe
   // parity to channel and fold the stripe index by two.
   function automatic stripe_sub_t split(
      input logic [AW-1:0] a,
      input logic [8:0]    rem
   );
      stripe_sub_t   r;
      logic [AW-1:0] stripe;
      logic [AW-1:0] to_bnd;
      stripe  = a >> STRIPE_LOG;
      to_bnd  = AW'(STRIPE_BEATS) - ((a & OFF_MASK) >> BEAT_LOG);
      r.n     = (AW'(rem) < to_bnd) ? rem : 9'(to_bnd);
      r.chan  = stripe[N_DDR_CHAN_BITS-1:0];
      r.laddr = ((stripe >> 1) << STRIPE_LOG) | (a & OFF_MASK);
      r.last  = (rem == r.n);
      return r;
   endfunction

   assign accept = s_awready_q & s_awvalid;
   assign aw_cmp = aw_done_q | (m_awvalid_q & m_awready);
   assign mx_cmp = mx_done_q | (mx_valid_q & mux.ready);

   assign a_nxt   = a_q + (AW'(n_q) << BEAT_LOG);
   assign rem_nxt = rem_q - n_q;

   // Idle splits the incoming request; issue splits the remainder.
   assign in_a   = (state_q == ST_IDLE) ? s_awaddr : a_nxt;
   assign in_rem = (state_q == ST_IDLE) ? ({1'b0, s_awlen} + 9'd1)
                                        : rem_nxt;
   assign sp     = split(in_a, in_rem);

   stripe_credit_cnt #(
      .MAX (MAX_OUTSTANDING)
   ) u_credit (
      .clk_i  (aclk),
      .rst_i  (areset),
      .inc_i  (b_cpl),
      .dec_i  (accept),
      .zero_o (cr_zero)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         rem_q       <= '0;
         n_q         <= '0;
         last_q      <= 1'b0;
         aw_done_q   <= 1'b0;
         mx_done_q   <= 1'b0;
         s_awready_q <= 1'b0;
         m_awvalid_q <= 1'b0;
         mx_valid_q  <= 1'b0;
         m_awaddr_q  <= '0;
         m_awlen_q   <= '0;
         m_awid_q    <= '0;
         m_awchan_q  <= '0;
         mx_data_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q     <= ST_ISSUE;
                  s_awready_q <= 1'b0;
                  a_q         <= s_awaddr;
                  rem_q       <= in_rem;
                  n_q         <= sp.n;
                  last_q      <= sp.last;
                  m_awid_q    <= s_awid;
                  m_awaddr_q  <= sp.laddr;
                  m_awlen_q   <= 8'(sp.n - 9'd1);
                  m_awchan_q  <= sp.chan;
                  mx_data_q   <= stripe_mux_pack(sp.last, sp.chan[0],
                                                 8'(sp.n - 9'd1));
                  m_awvalid_q <= 1'b1;
                  mx_valid_q  <= 1'b1;
               end else begin
                  s_awready_q <= ~cr_zero;
               end
            end
            ST_ISSUE: begin
               if (aw_cmp && mx_cmp) begin
                  aw_done_q <= 1'b0;
                  mx_done_q <= 1'b0;
                  if (last_q) begin
                     state_q     <= ST_IDLE;
                     m_awvalid_q <= 1'b0;
                     mx_valid_q  <= 1'b0;
                     s_awready_q <= ~cr_zero;
                  end else begin
                     a_q         <= a_nxt;
                     rem_q       <= rem_nxt;
                     n_q         <= sp.n;
                     last_q      <= sp.last;
                     m_awaddr_q  <= sp.laddr;
                     m_awlen_q   <= 8'(sp.n - 9'd1);
                     m_awchan_q  <= sp.chan;
                     mx_data_q   <= stripe_mux_pack(sp.last, sp.chan[0],
                                                    8'(sp.n - 9'd1));
                     m_awvalid_q <= 1'b1;
                     mx_valid_q  <= 1'b1;
                  end
               end else begin
                  // Each side retires independently; a finished
                  // side stays quiet until the other catches up.
                  aw_done_q   <= aw_cmp;
                  mx_done_q   <= mx_cmp;
                  m_awvalid_q <= ~aw_cmp;
                  mx_valid_q  <= ~mx_cmp;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_awready = s_awready_q;
   assign m_awvalid = m_awvalid_q;
   assign m_awaddr  = m_awaddr_q;
   assign m_awlen   = m_awlen_q;
   assign m_awid    = m_awid_q;
   assign m_awchan  = m_awchan_q;
   assign mux.valid = mx_valid_q;
   assign mux.data  = mx_data_q;

endmodule
